// File: rtl/volume_pkg.sv
// volume_pkg: shared level width, controller states and default timing for volume_ctrl.
package volume_pkg;
    localparam int LEVEL_W             = 4;
    localparam int DEF_DEBOUNCE_CYCLES = 4;
    localparam int DEF_REPEAT_DELAY    = 16;
    localparam int DEF_REPEAT_RATE     = 4;
    localparam int DEF_MAX_LEVEL       = 15;
    typedef enum logic [2:0] {IDLE, HOLD, REPEAT, RAMP_DOWN, MUTED, RAMP_UP} ctrl_state_t;
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchroniser plus counter; the level follows the input once it
// has differed from the debounced value for DEBOUNCE_CYCLES consecutive cycles.
module btn_debounce
    import volume_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic n_reset,
    input  logic btn_i,
    output logic level_o
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_q;
    logic          level_q, level_d, differ;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        differ  = sync_q[1] != level_q;
        level_d = level_q ^ (differ && cnt_q == LAST);
        cnt_d   = (!differ || cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            sync_q  <= '0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q  <= {sync_q[0], btn_i};
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;
endmodule

// File: rtl/volume_ctrl.sv
// volume_ctrl: turns debounced up/down/mute buttons into guarded one-cycle step pulses,
// with auto-repeat and paced mute/unmute ramps driven by the fed-back volume level.
module volume_ctrl
    import volume_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE     = DEF_REPEAT_RATE,
    parameter int MAX_LEVEL       = DEF_MAX_LEVEL
) (
    input  logic               clk,
    input  logic               n_reset,
    input  logic               btn_up,
    input  logic               btn_down,
    input  logic               btn_mute,
    input  logic [LEVEL_W-1:0] volume,
    output logic               up,
    output logic               down,
    output logic               muted,
    output logic               busy
);
    localparam int CW = $clog2((REPEAT_DELAY > REPEAT_RATE ? REPEAT_DELAY : REPEAT_RATE) + 1);
    localparam logic [CW-1:0] DELAY_LAST = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] RATE_LAST  = CW'(REPEAT_RATE - 1);

    ctrl_state_t        state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [LEVEL_W-1:0] saved_q, saved_d;
    logic               dir_q, dir_d;
    logic [2:0]         btn, lvl, lvl_q, rise;
    logic               up_q, up_d, down_q, down_d, muted_q, muted_d, busy_q, busy_d;
    logic               step_up, step_dn, held, other;

    // bit 0 = up, bit 1 = down, bit 2 = mute
    assign btn  = {btn_mute, btn_down, btn_up};
    assign rise = lvl & ~lvl_q;

    for (genvar i = 0; i < 3; i++) begin : g_db
        btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk    (clk),
            .n_reset(n_reset),
            .btn_i  (btn[i]),
            .level_o(lvl[i])
        );
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        saved_d = saved_q;
        dir_d   = dir_q;
        step_up = 1'b0;
        step_dn = 1'b0;
        held    = dir_q ? lvl[0] : lvl[1];
        other   = dir_q ? lvl[1] : lvl[0];
        if (rise[2] && (state_q inside {IDLE, HOLD, REPEAT})) begin
            saved_d = volume;
            state_d = volume == '0 ? MUTED : RAMP_DOWN;
            cnt_d   = RATE_LAST;
        end else begin
            case (state_q)
                IDLE: if (!(lvl[0] && lvl[1]) && (rise[0] || rise[1])) begin
                    dir_d   = rise[0];
                    step_up = rise[0];
                    step_dn = !rise[0];
                    state_d = HOLD;
                    cnt_d   = '0;
                end
                HOLD, REPEAT: if (!held || other) begin
                    state_d = IDLE;
                end else if (cnt_q == (state_q == HOLD ? DELAY_LAST : RATE_LAST)) begin
                    step_up = dir_q;
                    step_dn = !dir_q;
                    state_d = REPEAT;
                    cnt_d   = '0;
                end
                RAMP_DOWN: if (rise[2]) begin
                    state_d = RAMP_UP;
                    cnt_d   = RATE_LAST;
                end else if (volume == '0) begin
                    state_d = MUTED;
                end else if (cnt_q == RATE_LAST) begin
                    step_dn = 1'b1;
                    cnt_d   = '0;
                end
                MUTED: if (rise[2]) begin
                    state_d = RAMP_UP;
                    cnt_d   = RATE_LAST;
                end
                RAMP_UP: if (rise[2]) begin
                    state_d = RAMP_DOWN;
                    cnt_d   = RATE_LAST;
                end else if (volume >= saved_q) begin
                    state_d = IDLE;
                end else if (cnt_q == RATE_LAST) begin
                    step_up = 1'b1;
                    cnt_d   = '0;
                end
                default: state_d = IDLE;
            endcase
        end
        // the FSM advances regardless; only the pulse itself is guarded at the limits
        up_d    = step_up && volume < LEVEL_W'(MAX_LEVEL);
        down_d  = step_dn && volume != '0;
        muted_d = state_d inside {RAMP_DOWN, MUTED, RAMP_UP};
        busy_d  = state_d inside {RAMP_DOWN, RAMP_UP};
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            saved_q <= '0;
            dir_q   <= 1'b0;
            lvl_q   <= '0;
            up_q    <= 1'b0;
            down_q  <= 1'b0;
            muted_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            saved_q <= saved_d;
            dir_q   <= dir_d;
            lvl_q   <= lvl;
            up_q    <= up_d;
            down_q  <= down_d;
            muted_q <= muted_d;
            busy_q  <= busy_d;
        end
    end

    assign up    = up_q;
    assign down  = down_q;
    assign muted = muted_q;
    assign busy  = busy_q;
endmodule

// File: tb/tb_volume_ctrl.sv
// tb_volume_ctrl: directed checks of press latency, auto-repeat, level guards and mute ramps
// against a behavioural volume counter that follows the up/down pulses one cycle later.
`timescale 1ns/1ps
module tb_volume_ctrl;
    logic       clk = 1'b0, n_reset = 1'b0;
    logic       btn_up = 1'b0, btn_down = 1'b0, btn_mute = 1'b0;
    logic [3:0] vol = 4'd0, load_val = 4'd0;
    logic       load = 1'b0;
    logic       up, down, muted, busy;
    logic       up_prev = 1'b0, dn_prev = 1'b0;
    int         n_tests = 0, n_fail = 0, n_bad = 0, cyc = 0;
    int         first, n0, k;
    int         up_t[$], dn_t[$];

    always #5 clk = ~clk;

    volume_ctrl dut (
        .clk     (clk),
        .n_reset (n_reset),
        .btn_up  (btn_up),
        .btn_down(btn_down),
        .btn_mute(btn_mute),
        .volume  (vol),
        .up      (up),
        .down    (down),
        .muted   (muted),
        .busy    (busy)
    );

    always @(posedge clk) vol <= load ? load_val : vol + {3'b0, up} - {3'b0, down};

    // pulse log plus protocol watch: single-cycle pulses, never both, never past the limits
    always @(negedge clk) begin
        cyc++;
        if (up) up_t.push_back(cyc);
        if (down) dn_t.push_back(cyc);
        if ((up && (up_prev || vol == 4'd15)) || (down && (dn_prev || vol == 4'd0)) || (up && down))
            n_bad++;
        up_prev = up;
        dn_prev = down;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_vol(input logic [3:0] v);
        load_val = v;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic tap_mute();
        btn_mute = 1'b1;
        cycles(8);
        btn_mute = 1'b0;
    endtask

    task automatic wait_busy(input logic lvl, input string tag);
        int n = 0;
        while (busy !== lvl && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(tag, int'(busy === lvl), 1);
    endtask

    function automatic int gaps_off(input int q[$], input int from, input int g);
        int n = 0;
        for (int i = from + 1; i < q.size(); i++) if (q[i] - q[i-1] != g) n++;
        return n;
    endfunction

    initial begin
        // reset with every button held, then release with only up still pressed
        btn_up = 1'b1; btn_down = 1'b1; btn_mute = 1'b1;
        set_vol(4'd5);
        check("reset_outs_1", int'({up, down, muted, busy}), 0);
        @(negedge clk);
        check("reset_outs_2", int'({up, down, muted, busy}), 0);
        btn_down = 1'b0; btn_mute = 1'b0; n_reset = 1'b1;
        first = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (up && first == 0) first = i;
        end
        check("rst_latency", first, 7);
        btn_up = 1'b0;
        cycles(25);
        check("rst_up_count", up_t.size(), 1);
        check("rst_vol", int'(vol), 6);

        // clean 10-cycle press: one step, no repeat
        set_vol(4'd5);
        up_t.delete();
        btn_up = 1'b1;
        first = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (up && first == 0) first = i;
        end
        btn_up = 1'b0;
        cycles(30);
        check("press_latency", first, 7);
        check("press_up_count", up_t.size(), 1);
        check("press_vol", int'(vol), 6);

        // down pressed while up is in its hold window cancels without a pulse
        set_vol(4'd5);
        up_t.delete(); dn_t.delete();
        btn_up = 1'b1;
        cycles(12);
        btn_down = 1'b1;
        cycles(30);
        btn_up = 1'b0; btn_down = 1'b0;
        cycles(30);
        check("other_up_count", up_t.size(), 1);
        check("other_dn_count", dn_t.size(), 0);

        // held down from 8: first step, +16, then every 4, stopping at 0
        set_vol(4'd8);
        dn_t.delete();
        btn_down = 1'b1;
        cycles(60);
        btn_down = 1'b0;
        cycles(20);
        check("rep_dn_count", dn_t.size(), 8);
        check("rep_vol", int'(vol), 0);
        check("rep_first_gap", dn_t.size() >= 2 ? dn_t[1] - dn_t[0] : -1, 16);
        check("rep_gaps_off", gaps_off(dn_t, 1, 4), 0);

        // bouncing input never settles; simultaneous press does nothing
        set_vol(4'd5);
        up_t.delete(); dn_t.delete();
        for (int i = 0; i < 20; i++) begin
            if (i % 2 == 0) btn_up = ~btn_up;
            @(negedge clk);
        end
        btn_up = 1'b0;
        cycles(10);
        check("bounce_ups", up_t.size(), 0);
        btn_up = 1'b1; btn_down = 1'b1;
        cycles(30);
        btn_up = 1'b0; btn_down = 1'b0;
        cycles(20);
        check("both_pulses", up_t.size() + dn_t.size(), 0);
        check("both_vol", int'(vol), 5);

        // mute at 6: six down steps to MUTED, then unmute restores 6
        set_vol(4'd6);
        up_t.delete(); dn_t.delete();
        tap_mute();
        check("mute_busy", int'(busy), 1);
        check("mute_muted", int'(muted), 1);
        wait_busy(1'b0, "mute_done");
        check("mute_dn_count", dn_t.size(), 6);
        check("mute_vol", int'(vol), 0);
        check("mute_held", int'(muted), 1);
        check("mute_gaps_off", gaps_off(dn_t, 0, 4), 0);
        tap_mute();
        check("unmute_busy", int'(busy), 1);
        wait_busy(1'b0, "unmute_done");
        check("unmute_muted", int'(muted), 0);
        check("unmute_up_count", up_t.size(), 6);
        check("unmute_vol", int'(vol), 6);
        check("unmute_gaps_off", gaps_off(up_t, 0, 4), 0);

        // reverse mid-ramp at 3 while up is held; up button stays ignored
        set_vol(4'd6);
        up_t.delete(); dn_t.delete();
        tap_mute();
        k = 0;
        while (vol != 4'd3 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("rev_reach_3", int'(vol), 3);
        btn_mute = 1'b1; btn_up = 1'b1;
        cycles(8);
        btn_mute = 1'b0;
        check("rev_busy", int'(busy), 1);
        check("rev_muted", int'(muted), 1);
        wait_busy(1'b0, "rev_done");
        check("rev_unmuted", int'(muted), 0);
        check("rev_vol", int'(vol), 6);
        check("rev_enough_ups", int'(up_t.size() >= 3), 1);
        check("rev_balanced", up_t.size(), dn_t.size());
        n0 = up_t.size();
        cycles(30);
        btn_up = 1'b0;
        cycles(20);
        check("rev_up_ignored", up_t.size(), n0);
        check("rev_final_vol", int'(vol), 6);

        check("protocol_violations", n_bad, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1);
    end
endmodule
